seven_segment_scan: RTL
=======================

SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 3: number of multiplexed digits, 1..8.
REQ-002 Parameter SCAN_DIV, default 1200: clock cycles per digit slot, at least 4.
REQ-003 Parameter DEAD_CYC, default 16: blanking cycles at the start of each slot, less than SCAN_DIV.
REQ-004 Parameter SEG_ACTIVE_LOW, default 1: 1 means oSEG bits drive low-true segments.
REQ-005 Parameter DIG_ACTIVE_LOW, default 1: 1 means oDIG_EN bits drive low-true digit enables.
REQ-006 iCLK  input  1  system clock; all logic is on the rising edge.
REQ-007 iRST  input  1  reset, synchronous, active-high.
REQ-008 iDATA  input  4*NUM_DIGITS  hex nibbles; nibble k, bits 4k+3:4k, belongs to digit k.
REQ-009 iDP  input  NUM_DIGITS  decimal point request per digit.
REQ-010 iBLANK  input  NUM_DIGITS  per-digit blank; 1 forces all segments off, including dp.
REQ-011 iLOAD  input  1  single-cycle strobe that captures iDATA, iDP and iBLANK.
REQ-012 oSEG  output  8  segment lines; bit7..bit1 = a..g, bit0 = dp; registered.
REQ-013 oDIG_EN  output  NUM_DIGITS  digit enables, one-hot when active; registered.
REQ-014 oFRAME  output  1  one-cycle pulse when the display register updates at the frame boundary.

Function
REQ-015 The slot counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, the digit index SHALL advance, with NUM_DIGITS-1 wrapping to 0.
REQ-016 The frame boundary SHALL be the cycle in which the index wraps to 0.
REQ-017 iLOAD=1 SHALL write the inputs into a pending register and set a pending flag; a later iLOAD before the boundary SHALL overwrite it (last wins).
REQ-018 At the frame boundary, a set pending flag SHALL copy pending to the display register, clear the flag and pulse oFRAME on the next cycle; with the flag clear, there SHALL be no copy and no pulse.
REQ-019 If iLOAD and the frame boundary occur in the same cycle, iDATA/iDP/iBLANK SHALL go directly to the display register, the flag SHALL be cleared and oFRAME SHALL pulse.
REQ-020 The display SHALL never show a mix of old and new data within one frame.
REQ-021 While counter < DEAD_CYC, oDIG_EN SHALL be all-inactive; otherwise only bit [index] SHALL be active.
REQ-022 oSEG SHALL be the active-high hex pattern of the current digit's nibble (0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E), OR dp in bit0, then inverted if SEG_ACTIVE_LOW.
REQ-023 Both outputs SHALL lag the counter/index state by exactly one clock.
REQ-024 A blanked digit SHALL still get its slot time, with segments off.

Reset
REQ-025 While iRST=1: counter=0, index=0, display and pending registers=0, flag clear, oFRAME=0, oSEG=all-off (8'hFF when SEG_ACTIVE_LOW) and oDIG_EN=all-inactive.
REQ-026 Reset asserted mid-slot SHALL take effect on the next edge; a pending load SHALL be discarded.
REQ-027 After reset deasserts, the first active slot SHALL be digit 0, starting with DEAD_CYC blanked cycles.

Configuration
REQ-028 Macro SEVEN_SEGMENT_SCAN_BLINK_EN, when defined, SHALL add input iBLINK [NUM_DIGITS-1:0], captured with iLOAD the same way as iBLANK.
REQ-029 With the macro defined, parameter BLINK_FRAMES (default 256) SHALL toggle a blink phase every BLINK_FRAMES frame boundaries.
REQ-030 With the macro defined, digits with iBLINK set SHALL be blanked while the phase is 1; reset SHALL clear the phase and its frame counter.
REQ-031 Without the macro, the iBLINK port, blink counter and phase SHALL be absent, and behaviour SHALL be as in REQ-015..REQ-027.

Structure
REQ-032 Package seven_segment_pkg SHALL hold the 16-entry hex segment constants, segment bit-position constants and the default SCAN_DIV/DEAD_CYC values.
REQ-033 Sub-module seven_segment_decode SHALL be the combinational nibble+dp+blank to active-high 8-bit pattern decoder; polarity SHALL be applied in seven_segment_scan.

Verification (NUM_DIGITS=3, SCAN_DIV=8, DEAD_CYC=2, both polarities low)
REQ-034 Hold iRST 3 cycles -> oSEG=8'hFF, oDIG_EN=3'b111, oFRAME=0 throughout; after release, oDIG_EN=3'b110 from cycle 3 to cycle 8.
REQ-035 Pulse iLOAD with iDATA=12'h3A7, iDP=3'b010 -> oFRAME at the next boundary; slots then show 7 (8'h1F), A+dp (8'h10), 3 (8'h0D).
REQ-036 Pulse iLOAD twice within one frame (12'h111, then 12'h222) -> only 222 is displayed; exactly one oFRAME pulse.
REQ-037 Assert iLOAD on the exact boundary cycle with 12'h456 -> the next frame shows 6, 5, 4 and oFRAME pulses.
REQ-038 iBLANK=3'b100 with iDP=3'b100 -> slot 2 has oDIG_EN=3'b011 and oSEG=8'hFF.
REQ-039 With SEVEN_SEGMENT_SCAN_BLINK_EN, BLINK_FRAMES=2 and iBLINK=3'b001 -> digit 0 is shown for 2 frames, blank for 2 frames, repeating.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: hex segment table, segment bit positions and scan timing defaults
package seven_segment_pkg;
  localparam int DEF_SCAN_DIV = 1200;
  localparam int DEF_DEAD_CYC = 16;
  localparam int SEG_A = 7;
  localparam int SEG_G = 1;
  localparam int SEG_DP = 0;
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };
endpackage

// File: rtl/seven_segment_decode.sv
// seven_segment_decode: hex nibble plus dp to active-high a..g,dp pattern; blank forces everything off
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  logic [7:0] pat;
  assign pat = HEX_SEG[nib];
  assign seg = blank ? 8'h00 : {pat[SEG_A:SEG_G], pat[SEG_DP] | dp};
endmodule

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: multiplexed hex display scanner with frame-synchronous updates (blink via SEVEN_SEGMENT_SCAN_BLINK_EN)
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int DEAD_CYC       = DEF_DEAD_CYC,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 256
`endif
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLANK,
  input  logic                    iLOAD,
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   iBLINK,
`endif
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oDIG_EN,
  output logic                    oFRAME
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  localparam int WW = 7 * NUM_DIGITS;
`else
  localparam int WW = 6 * NUM_DIGITS;
`endif
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? '1 : '0;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [WW-1:0]         load_word, pend, disp;
  logic                  pend_flag, wrap, bnd, dp_on, dig_blank;
  logic [3:0]            nib;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] en;

  // load/display words are {blink, blank, dp, data} so one copy moves a whole frame's worth at once
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  assign load_word = {iBLINK, iBLANK, iDP, iDATA};
`else
  assign load_word = {iBLANK, iDP, iDATA};
`endif
  assign wrap  = int'(cnt) == SCAN_DIV - 1;
  assign bnd   = wrap && int'(idx) == NUM_DIGITS - 1;
  assign nib   = disp[4*int'(idx) +: 4];
  assign dp_on = disp[4*NUM_DIGITS + int'(idx)];
  assign en    = int'(cnt) >= DEAD_CYC ? NUM_DIGITS'(1) << idx : '0;

`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] bcnt;
  logic          phase;
  // blink phase flips after every BLINK_FRAMES frame boundaries
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bnd) begin
      bcnt  <= int'(bcnt) == BLINK_FRAMES - 1 ? '0 : bcnt + 1'b1;
      phase <= int'(bcnt) == BLINK_FRAMES - 1 ? ~phase : phase;
    end
  end
  assign dig_blank = disp[5*NUM_DIGITS + int'(idx)] | (disp[6*NUM_DIGITS + int'(idx)] & phase);
`else
  assign dig_blank = disp[5*NUM_DIGITS + int'(idx)];
`endif

  seven_segment_decode u_dec (
    .nib   (nib),
    .dp    (dp_on),
    .blank (dig_blank),
    .seg   (seg)
  );

  // slot timing plus double-buffered display: new data only lands on the frame boundary
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt       <= '0;
      idx       <= '0;
      pend      <= '0;
      disp      <= '0;
      pend_flag <= 1'b0;
      oFRAME    <= 1'b0;
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      idx    <= wrap ? (bnd ? '0 : idx + 1'b1) : idx;
      oFRAME <= bnd && (pend_flag || iLOAD);
      if (bnd && iLOAD) begin
        disp      <= load_word;
        pend_flag <= 1'b0;
      end else if (bnd && pend_flag) begin
        disp      <= pend;
        pend_flag <= 1'b0;
      end else if (iLOAD) begin
        pend      <= load_word;
        pend_flag <= 1'b1;
      end
    end
  end

  // registered pins with polarity applied; one clock behind the slot state
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSEG    <= SEG_OFF;
      oDIG_EN <= DIG_OFF;
    end else begin
      oSEG    <= SEG_ACTIVE_LOW != 0 ? ~seg : seg;
      oDIG_EN <= DIG_ACTIVE_LOW != 0 ? ~en : en;
    end
  end
endmodule
